scan_display_mux: RTL

Parametrised time-multiplexed scanner for seven-segment digit banks. It rotates through N_DIGITS digit slots at a programmable slot rate and skips digits disabled by a mask. A dead-time window at the start of each slot suppresses ghosting. New digit data and masks are double-buffered so that updates land only at frame boundaries. It sits between the lab's data/state logic and the board's digit-select/decoder pins, and replaces the fixed six-slot display mux.

---
 rtl/display_pkg.sv | 34 +++
 rtl/rr_next_idx.sv | 47 ++++
 rtl/scan_display_mux.sv | 124 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants and helpers for the scanned display mux.
//   DIGIT_W     - width of one digit value (hex nibble).
//   MAX_DIGITS  - widest digit bank supported; masks are zero-extended to this.
//   clog2_u     - ceiling log2 for deriving index and counter widths.
//   highest_set - index of the highest set bit of a mask, 0 for an empty mask.
package display_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 16;

    function automatic int unsigned clog2_u(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned highest_set(input logic [MAX_DIGITS-1:0] mask);
        int unsigned pos;
        pos = 0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (mask[i]) begin
                pos = i;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/rr_next_idx.sv
// rr_next_idx: combinational circular next-set-bit finder.
//   mask         - candidate slots, bit i set means slot i may be selected.
//   idx          - currently selected slot.
//   force_lowest - ignore idx and return the lowest set bit.
//   nxt          - next set bit strictly above idx, wrapping to the lowest set
//                  bit; 0 when mask is empty.
//   any          - mask has at least one bit set.
module rr_next_idx #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic [N-1:0]  mask,
    input  logic [AW-1:0] idx,
    input  logic          force_lowest,
    output logic [AW-1:0] nxt,
    output logic          any
);

    logic [AW-1:0] lowest;
    logic [AW-1:0] above;
    logic          found;

    always_comb begin
        lowest = '0;
        above  = '0;
        found  = 1'b0;

        // Scan downward so the last hit is the lowest set bit.
        for (int unsigned i = N; i > 0; i--) begin
            if (mask[i-1]) begin
                lowest = AW'(i - 1);
            end
        end

        // First set bit strictly above the current slot.
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && mask[i] && (i > 32'(idx))) begin
                above = AW'(i);
                found = 1'b1;
            end
        end

        any = |mask;
        nxt = (force_lowest || !found) ? lowest : above;
    end

endmodule

// File: rtl/scan_display_mux.sv
// scan_display_mux: time-multiplexed scanner for a bank of seven-segment digits.
// Rotates through the enabled digit slots, TICK_DIV clocks per slot, with the
// first BLANK_CYC clocks of each slot dark to suppress ghosting. Digit data and
// the enable mask are double-buffered: load captures into staging, and staging
// is committed to the displayed shadow copy only at a frame boundary.
//   clk        - sole clock, rising edge.
//   rst        - synchronous, active-low reset.
//   digits     - staging digit values, digit i in bits [4i+3:4i].
//   en_mask    - staging enable mask, bit i set means digit i is scanned.
//   load       - single-cycle capture strobe for digits/en_mask.
//   out        - value of the selected digit (registered).
//   an         - encoded index of the selected digit (registered).
//   an_valid   - an/out drive a lit digit; low means all digits dark.
//   frame_done - one-cycle pulse per frame boundary.
//   pending    - staged data is waiting for a frame boundary.
module scan_display_mux
    import display_pkg::*;
#(
    parameter  int N_DIGITS  = 8,
    parameter  int TICK_DIV  = 100000,
    parameter  int BLANK_CYC = 16,
    localparam int AW        = clog2_u(N_DIGITS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIGIT_W*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]         en_mask,
    input  logic                        load,
    output logic [DIGIT_W-1:0]          out,
    output logic [AW-1:0]               an,
    output logic                        an_valid,
    output logic                        frame_done,
    output logic                        pending
);

    localparam int CW = clog2_u(TICK_DIV);

    typedef logic [N_DIGITS-1:0][DIGIT_W-1:0] digit_bank_t;

    logic [CW-1:0]       cnt;
    logic [AW-1:0]       idx;
    digit_bank_t         dig_st;
    digit_bank_t         dig_sh;
    logic [N_DIGITS-1:0] mask_st;
    logic [N_DIGITS-1:0] mask_sh;

    logic                slot_end;
    logic                boundary;
    logic                commit;
    digit_bank_t         commit_dig;
    logic [N_DIGITS-1:0] commit_mask;
    logic [N_DIGITS-1:0] eff_mask;
    logic [AW-1:0]       nxt;
    logic                any;

    always_comb begin
        slot_end = (cnt == CW'(TICK_DIV - 1));
        // The frame closes on the last slot of the highest enabled digit; with
        // nothing enabled every slot is a complete (dark) frame.
        boundary = slot_end &&
                   ((mask_sh == '0) ||
                    (32'(idx) == highest_set(MAX_DIGITS'(mask_sh))));
        commit   = boundary && (pending || load);

        // A load on the boundary cycle bypasses staging and lands directly.
        commit_dig  = load ? digit_bank_t'(digits) : dig_st;
        commit_mask = load ? en_mask : mask_st;

        eff_mask = commit ? commit_mask : mask_sh;
    end

    rr_next_idx #(
        .N  (N_DIGITS),
        .AW (AW)
    ) u_next (
        .mask         (eff_mask),
        .idx          (idx),
        .force_lowest (commit),
        .nxt          (nxt),
        .any          (any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            dig_st     <= '0;
            mask_st    <= '1;
            dig_sh     <= '0;
            mask_sh    <= '1;
            pending    <= 1'b0;
            out        <= '0;
            an         <= '0;
            an_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= any ? nxt : '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (load) begin
                dig_st  <= digit_bank_t'(digits);
                mask_st <= en_mask;
            end

            if (commit) begin
                dig_sh  <= commit_dig;
                mask_sh <= commit_mask;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            out        <= dig_sh[idx];
            an         <= idx;
            an_valid   <= (int'(cnt) >= BLANK_CYC) && mask_sh[idx];
            frame_done <= boundary;
        end
    end

endmodule
